// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit type, port indices, FSM states and XY route helper
package noc_pkg;

  localparam int NUM_PORTS = 5;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int SOUTH = 2;
  localparam int EAST  = 3;
  localparam int WEST  = 4;

  typedef struct packed {
    logic [1:0]  dest_x;
    logic [1:0]  dest_y;
    logic [27:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ROUTE      = 2'd1,
    WAIT_GRANT = 2'd2
  } port_state_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [NUM_PORTS-1:0] xy_route(input logic [1:0] dest_x,
                                                    input logic [1:0] dest_y,
                                                    input logic [1:0] x_id,
                                                    input logic [1:0] y_id);
    logic [NUM_PORTS-1:0] onehot;
    onehot = '0;
    if (dest_x > x_id)      onehot[EAST]  = 1'b1;
    else if (dest_x < x_id) onehot[WEST]  = 1'b1;
    else if (dest_y > y_id) onehot[NORTH] = 1'b1;
    else if (dest_y < y_id) onehot[SOUTH] = 1'b1;
    else                    onehot[LOCAL] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// rtl/noc_flit_fifo.sv - circular flit buffer with occupancy count
module noc_flit_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  flit_t         wdata,
  output flit_t         rdata,
  output logic          full,
  output logic [CW-1:0] count
);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr];

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap explicitly at DEPTH-1; count tracks push/pop together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// rtl/noc_input_port.sv - NoC router input port: flit FIFO, XY route and grant handshake (optional NOC_PORT_STATS_EN counters)
module noc_input_port
  import noc_pkg::*;
#(
  parameter int X_ID  = 0,
  parameter int Y_ID  = 0,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_flit,
  output logic [4:0]  req,
  input  logic [4:0]  grant,
  output logic [31:0] out_flit,
  output logic        grant_err
`ifdef NOC_PORT_STATS_EN
  ,
  output logic [15:0] flit_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  port_state_t    state_q, state_d;
  logic [4:0]     req_d;
  logic           push, pop;
  logic           full;
  logic [CW-1:0]  count;
  flit_t          head;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign out_flit = head;

  noc_flit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (flit_t'(in_flit)),
    .rdata (head),
    .full  (full),
    .count (count)
  );

  // Next-state and request decode; req only changes on entering or leaving WAIT_GRANT.
  always_comb begin
    state_d = state_q;
    req_d   = req;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) state_d = ROUTE;
      end
      ROUTE: begin
        req_d   = xy_route(head.dest_x, head.dest_y, 2'(X_ID), 2'(Y_ID));
        state_d = WAIT_GRANT;
      end
      WAIT_GRANT: begin
        if ((grant & req) != '0) begin
          pop     = 1'b1;
          req_d   = '0;
          state_d = ((count != CW'(1)) || push) ? ROUTE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req       <= '0;
      grant_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      req       <= req_d;
      grant_err <= (state_q != WAIT_GRANT) ? (|grant) : (|(grant & ~req));
    end
  end

`ifdef NOC_PORT_STATS_EN
  // Saturating counters of delivered flits and grant-starved cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (flit_cnt != 16'hFFFF)) flit_cnt <= flit_cnt + 1'b1;
      if ((state_q == WAIT_GRANT) && !pop && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// tb/tb_noc_input_port.sv - self-checking bench for noc_input_port (X_ID=1, Y_ID=1, DEPTH=4)
module tb_noc_input_port;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_flit;
  logic [4:0]  req;
  logic [4:0]  grant;
  logic [31:0] out_flit;
  logic        grant_err;
`ifdef NOC_PORT_STATS_EN
  logic [15:0] flit_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  noc_input_port #(.X_ID(1), .Y_ID(1), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flit   (in_flit),
    .req       (req),
    .grant     (grant),
    .out_flit  (out_flit),
    .grant_err (grant_err)
`ifdef NOC_PORT_STATS_EN
    ,
    .flit_cnt  (flit_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference XY routing for a router at (1,1), written directly from the rule.
  function automatic logic [4:0] model_route(input logic [31:0] f);
    int dx, dy, port;
    dx = int'(f[31:30]);
    dy = int'(f[29:28]);
    if (dx > 1)      port = 3;
    else if (dx < 1) port = 4;
    else if (dy > 1) port = 1;
    else if (dy < 1) port = 2;
    else             port = 0;
    return 5'(1 << port);
  endfunction

  function automatic logic [31:0] mk_flit(input int dx, input int dy);
    return {dx[1:0], dy[1:0], 28'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    grant = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] f);
    in_flit = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (req != '0) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL reset_req: got %b exp 00000", req); end
    checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL reset_grant_err: got %b exp 0", grant_err); end
  endtask

  task automatic test_single();
    logic [31:0] f;
    do_reset();
    f = mk_flit(3, 1);
    do_push(f);
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL single_req_c1: got %b exp 00000", req); end
    tick();
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL single_req_c2: got %b exp 00000", req); end
    tick();
    checks++; if (req !== 5'b01000) begin errors++; $display("FAIL single_req_lat: got %b exp 01000", req); end
    checks++; if (out_flit !== f) begin errors++; $display("FAIL single_out_flit: got %h exp %h", out_flit, f); end
    grant = 5'b01000;
    tick();
    grant = '0;
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL single_req_clear: got %b exp 00000", req); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b exp 1", in_ready); end
    checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL single_grant_err: got %b exp 0", grant_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] fl [3];
    logic [4:0]  exp_req [3];
    bit ok;
    do_reset();
    fl[0] = mk_flit(1, 1); exp_req[0] = 5'b00001;
    fl[1] = mk_flit(0, 2); exp_req[1] = 5'b10000;
    fl[2] = mk_flit(1, 0); exp_req[2] = 5'b00100;
    for (int i = 0; i < 3; i++) do_push(fl[i]);
    for (int i = 0; i < 3; i++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout[%0d]: got no req exp %b", i, exp_req[i]); end
      checks++; if (req !== exp_req[i]) begin errors++; $display("FAIL b2b_req[%0d]: got %b exp %b", i, req, exp_req[i]); end
      checks++; if (out_flit !== fl[i]) begin errors++; $display("FAIL b2b_flit[%0d]: got %h exp %h", i, out_flit, fl[i]); end
      grant = exp_req[i];
      tick();
      grant = '0;
    end
    tick();
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL b2b_drained: got %b exp 00000", req); end
  endtask

  task automatic test_full();
    logic [31:0] fl [5];
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) fl[i] = mk_flit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    for (int i = 0; i < 4; i++) do_push(fl[i]);
    in_flit = fl[4];
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready[%0d]: got %b exp 0", c, in_ready); end
      tick();
    end
    checks++; if (req !== model_route(fl[0])) begin errors++; $display("FAIL full_req: got %b exp %b", req, model_route(fl[0])); end
    checks++; if (out_flit !== fl[0]) begin errors++; $display("FAIL full_head: got %h exp %h", out_flit, fl[0]); end
    grant = model_route(fl[0]);
    tick();
    grant = '0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_refilled: got %b exp 0", in_ready); end
    for (int i = 1; i < 5; i++) begin
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_drain_timeout[%0d]: got no req", i); end
      checks++; if (out_flit !== fl[i]) begin errors++; $display("FAIL full_drain_flit[%0d]: got %h exp %h", i, out_flit, fl[i]); end
      grant = model_route(fl[i]);
      tick();
      grant = '0;
    end
  endtask

  task automatic test_grant_err();
    logic [31:0] f;
    bit ok;
    do_reset();
    f = mk_flit(1, 2);
    do_push(f);
    wait_req(ok);
    checks++; if (req !== 5'b00010) begin errors++; $display("FAIL gerr_req: got %b exp 00010", req); end
    grant = 5'b00100;
    tick();
    grant = '0;
    checks++; if (grant_err !== 1'b1) begin errors++; $display("FAIL gerr_pulse: got %b exp 1", grant_err); end
    checks++; if (req !== 5'b00010) begin errors++; $display("FAIL gerr_req_held: got %b exp 00010", req); end
    checks++; if (out_flit !== f) begin errors++; $display("FAIL gerr_no_pop: got %h exp %h", out_flit, f); end
    tick();
    checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL gerr_one_cycle: got %b exp 0", grant_err); end
    grant = 5'b00010;
    tick();
    grant = '0;
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL gerr_final_pop: got %b exp 00000", req); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] f;
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) do_push(mk_flit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: got no req"); end
    rst = 1'b1;
    #1;
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL rstmid_req: got %b exp 00000", req); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b exp 1", in_ready); end
    tick();
    rst = 1'b0;
    grant = 5'b00001;
    tick();
    grant = '0;
    checks++; if (grant_err !== 1'b1) begin errors++; $display("FAIL rstmid_grant_err: got %b exp 1", grant_err); end
    tick(); tick(); tick();
    checks++; if (req !== 5'b0) begin errors++; $display("FAIL rstmid_empty: got %b exp 00000", req); end
    f = mk_flit(2, 3);
    do_push(f);
    wait_req(ok);
    checks++; if (out_flit !== f) begin errors++; $display("FAIL rstmid_new_head: got %h exp %h", out_flit, f); end
    checks++; if (req !== 5'b01000) begin errors++; $display("FAIL rstmid_new_req: got %b exp 01000", req); end
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [4:0]  r, g;
    bit          acc, popd, experr;
    logic [31:0] pushed;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_flit  = $urandom;
      r = req;
      case ($urandom_range(0, 5))
        0:       g = 5'(1 << $urandom_range(0, 4));
        1, 2:    g = r;
        default: g = '0;
      endcase
      grant  = g;
      pushed = in_flit;
      acc    = in_valid && in_ready;
      popd   = (g & r) != '0;
      experr = (g & ~r) != '0;
      tick();
      if (popd && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(pushed);
      checks++; if (in_ready !== (q.size() < 4)) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b exp %b", c, in_ready, q.size() < 4); end
      checks++; if (grant_err !== experr) begin errors++; $display("FAIL rnd_grant_err[%0d]: got %b exp %b", c, grant_err, experr); end
      if (req != '0) begin
        checks++; if (q.size() == 0) begin errors++; $display("FAIL rnd_req_empty[%0d]: got %b exp 00000", c, req); end
        else begin
          checks++; if (req !== model_route(q[0])) begin errors++; $display("FAIL rnd_req[%0d]: got %b exp %b", c, req, model_route(q[0])); end
          checks++; if (out_flit !== q[0]) begin errors++; $display("FAIL rnd_flit[%0d]: got %h exp %h", c, out_flit, q[0]); end
        end
      end
    end
    in_valid = 1'b0;
    grant = '0;
  endtask

`ifdef NOC_PORT_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d exp 0", stall_cnt); end
    do_push(mk_flit(0, 0));
    wait_req(ok);
    for (int i = 0; i < 7; i++) tick();
    grant = 5'b10000;
    tick();
    grant = '0;
    checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL stats_stall: got %0d exp 7", stall_cnt); end
    checks++; if (flit_cnt !== 16'd1) begin errors++; $display("FAIL stats_flit: got %0d exp 1", flit_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_flit = '0;
    grant = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_grant_err();
    test_reset_mid();
    test_random();
`ifdef NOC_PORT_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
